fp_aux_unit: RTL and testbench

- Shared auxiliary single-precision (IEEE-754 binary32) unit for the iterative-series controller.
- Performs one of three operations per request:
  - fraction check of b (is b non-integer);
  - square of a;
  - quotient a / b.
- Uses a one-pulse start / one-pulse done handshake. The controller feeds results into its summation path.

---
 rtl/fp_aux_unit.sv | 192 +++++++++++++++++++
 tb/tb_fp_aux_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_aux_unit.sv
// Shared binary32 helper: fraction check of b, square of a, or truncated quotient a/b.
// Start/done pulse handshake. Results are loaded in DONE and held until the next DONE or reset.
module fp_aux_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        r_i,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        r_o,
  output logic        busy,
  output logic        err,
  output logic [31:0] res
);

  localparam int unsigned DW = 32;
  localparam int unsigned EW = 8;
  localparam int unsigned FW = 23;
  localparam int unsigned MW = 24;
  localparam int unsigned XW = 11;
  localparam int unsigned CW = 5;
  localparam int unsigned PW = 25;

  localparam logic [1:0]    OP_POW2   = 2'b01;
  localparam logic [1:0]    OP_DIV    = 2'b10;
  localparam logic [EW-1:0] E_MAX     = 8'd255;
  localparam logic [EW-1:0] E_BIAS    = 8'd127;
  localparam logic [EW-1:0] E_INT     = 8'd150;
  localparam logic [CW-1:0] DIV_STEPS = 5'd23;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_NORM, S_DONE} state_t;

  state_t          state;
  logic            held;
  logic [1:0]      op_q;
  logic [DW-1:0]   a_q;
  logic [DW-1:0]   b_q;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   prod_q;
  logic [MW-1:0]   rem_q;
  logic [MW:0]     quo_q;

  logic            sa_c, sb_c;
  logic [EW-1:0]   ea_c, eb_c;
  logic [FW-1:0]   fa_c, fb_c;
  logic [MW-1:0]   ma_c, mb_c;

  assign sa_c = a_q[31];
  assign sb_c = b_q[31];
  assign ea_c = a_q[30:23];
  assign eb_c = b_q[30:23];
  assign fa_c = a_q[22:0];
  assign fb_c = b_q[22:0];
  assign ma_c = {1'b1, fa_c};
  assign mb_c = {1'b1, fb_c};

  // Square keeps only bits 47:23 of the 48-bit mantissa product.
  logic [2*MW-1:0] mul_c;
  assign mul_c = 48'(ma_c) * 48'(ma_c);

  // Restoring divider: integer quotient bit, then one fraction bit per ITER cycle.
  logic          q0_c;
  logic [MW-1:0] rem0_c;
  logic [MW:0]   sh_c;
  logic          ge_c;
  logic [MW-1:0] rem1_c;

  assign q0_c   = (ma_c >= mb_c);
  assign rem0_c = q0_c ? (ma_c - mb_c) : ma_c;
  assign sh_c   = {rem_q, 1'b0};
  assign ge_c   = (sh_c >= {1'b0, mb_c});
  assign rem1_c = ge_c ? 24'(sh_c - {1'b0, mb_c}) : sh_c[MW-1:0];

  // Fraction check: the low (150-e) mantissa bits hold the fractional part.
  logic [CW-1:0] fr_sh_c;
  logic [FW-1:0] fr_mask_c;
  logic          fr_c;

  assign fr_sh_c   = 5'(E_INT - eb_c);
  assign fr_mask_c = 23'((24'd1 << fr_sh_c) - 24'd1);

  always_comb begin
    fr_c = 1'b0;
    if (eb_c == '0)          fr_c = 1'b0;
    else if (eb_c == E_MAX)  fr_c = 1'b1;
    else if (eb_c < E_BIAS)  fr_c = 1'b1;
    else if (eb_c >= E_INT)  fr_c = 1'b0;
    else                     fr_c = |(fb_c & fr_mask_c);
  end

  // Final packing of the selected operation, loaded into res/err on entry to DONE.
  logic signed [XW-1:0] pexp_c;
  logic signed [XW-1:0] dexp_c;
  logic [DW-1:0]        res_c;
  logic                 err_c;

  always_comb begin
    res_c  = '0;
    err_c  = 1'b0;
    pexp_c = $signed({2'b00, ea_c, 1'b0}) - $signed(11'd127) + $signed({10'd0, prod_q[24]});
    dexp_c = $signed({3'b000, ea_c}) - $signed({3'b000, eb_c}) + $signed(11'd127)
             - $signed({10'd0, ~quo_q[24]});
    case (op_q)
      OP_POW2: begin
        if (ea_c == E_MAX)              err_c = 1'b1;
        else if (ea_c == '0)            res_c = '0;
        else if (pexp_c >= 11'sd255)    err_c = 1'b1;
        else if (pexp_c <= 11'sd0)      res_c = '0;
        else res_c = {1'b0, pexp_c[7:0], (prod_q[24] ? prod_q[23:1] : prod_q[22:0])};
      end
      OP_DIV: begin
        if (ea_c == E_MAX || eb_c == E_MAX) err_c = 1'b1;
        else if (eb_c == '0)                err_c = 1'b1;
        else if (ea_c == '0)                res_c = {sa_c ^ sb_c, 31'd0};
        else if (dexp_c >= 11'sd255)        err_c = 1'b1;
        else if (dexp_c <= 11'sd0)          res_c = '0;
        else res_c = {sa_c ^ sb_c, dexp_c[7:0], (quo_q[24] ? quo_q[23:1] : quo_q[22:0])};
      end
      default: res_c = {31'd0, fr_c};
    endcase
  end

  // Control FSM and datapath registers; held blocks restart until r_i has dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      held   <= 1'b0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      prod_q <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      r_o    <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
      res    <= '0;
    end else begin
      if (!r_i) held <= 1'b0;
      case (state)
        S_IDLE: begin
          if (r_i && !held) begin
            held  <= 1'b1;
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            busy  <= 1'b1;
            state <= S_PREP;
          end
        end
        S_PREP: begin
          rem_q <= rem0_c;
          quo_q <= {24'd0, q0_c};
          if (op_q == OP_POW2) begin
            cnt   <= '0;
            state <= S_ITER;
          end else if (op_q == OP_DIV) begin
            cnt   <= DIV_STEPS;
            state <= S_ITER;
          end else begin
            state <= S_NORM;
          end
        end
        S_ITER: begin
          if (op_q == OP_POW2) begin
            prod_q <= 25'(mul_c >> 23);
            state  <= S_NORM;
          end else begin
            rem_q <= rem1_c;
            quo_q <= {quo_q[MW-1:0], ge_c};
            if (cnt == '0) state <= S_NORM;
            else           cnt   <= cnt - 5'd1;
          end
        end
        S_NORM: begin
          res   <= res_c;
          err   <= err_c;
          r_o   <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          r_o   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_aux_unit.sv
// Directed bench for fp_aux_unit: checks results, flags, done latency and handshake corner cases.
module tb_fp_aux_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        r_i;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        r_o;
  logic        busy;
  logic        err;
  logic [31:0] res;

  int checks = 0;
  int errors = 0;

  fp_aux_unit dut (
    .clk   (clk),
    .reset (reset),
    .r_i   (r_i),
    .op    (op),
    .a     (a),
    .b     (b),
    .r_o   (r_o),
    .busy  (busy),
    .err   (err),
    .res   (res)
  );

  always #5 clk = ~clk;

  // One-cycle start pulse; operands are scrambled right after the start edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic [31:0] rv, output logic ev,
                        output logic bz, output logic ro_nxt, output logic bz_nxt);
    @(negedge clk);
    op = o; a = x; b = y; r_i = 1'b1;
    @(posedge clk); #1;
    r_i = 1'b0; a = 32'hDEADBEEF; b = 32'h3FC00001; op = 2'b01;
    lat = 0; rv = '0; ev = 1'b0; bz = 1'b0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      if (r_o) begin
        lat = k; rv = res; ev = err; bz = busy;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    ro_nxt = r_o; bz_nxt = busy;
  endtask

  task automatic test_reset();
    reset = 1'b0; r_i = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({r_o, busy, err, res} !== 35'd0) begin
      errors++;
      $display("FAIL reset_state got r_o=%b busy=%b err=%b res=%h want all 0", r_o, busy, err, res);
    end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_checkfr();
    logic [31:0] bv [10] = '{32'h40200000, 32'h40400000, 32'h00000000, 32'h3F000000, 32'h4B000000,
                             32'h3FC00000, 32'h7F800000, 32'hC0200000, 32'h00400000, 32'h40200000};
    logic [31:0] ev_t [10] = '{32'd1, 32'd0, 32'd0, 32'd1, 32'd0, 32'd1, 32'd1, 32'd1, 32'd0, 32'd1};
    logic [1:0]  ov [10] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11};
    int lat; logic [31:0] rv; logic ev, bz, ro_n, bz_n;
    for (int i = 0; i < 10; i++) begin
      run_op(ov[i], 32'h40E00000, bv[i], lat, rv, ev, bz, ro_n, bz_n);
      checks++;
      if (rv !== ev_t[i] || ev !== 1'b0) begin
        errors++;
        $display("FAIL checkfr[%0d] b=%h got res=%h err=%b want res=%h err=0", i, bv[i], rv, ev, ev_t[i]);
      end
      checks++;
      if (lat != 3) begin
        errors++;
        $display("FAIL checkfr_lat[%0d] got %0d want 3", i, lat);
      end
      if (i == 0) begin
        checks++;
        if ({bz, ro_n, bz_n} !== 3'b100) begin
          errors++;
          $display("FAIL checkfr_pulse got busy@ro=%b r_o_next=%b busy_next=%b want 1 0 0", bz, ro_n, bz_n);
        end
      end
    end
  endtask

  task automatic test_pow2();
    logic [31:0] av [7] = '{32'h40400000, 32'hC0000000, 32'h7F000000, 32'h1F800000,
                            32'h80000000, 32'h7F800000, 32'h3FC00000};
    logic [31:0] rx [7] = '{32'h41100000, 32'h40800000, 32'h00000000, 32'h00000000,
                            32'h00000000, 32'h00000000, 32'h40100000};
    logic        ex [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int lat; logic [31:0] rv; logic ev, bz, ro_n, bz_n;
    for (int i = 0; i < 7; i++) begin
      run_op(2'b01, av[i], 32'h40000000, lat, rv, ev, bz, ro_n, bz_n);
      checks++;
      if (rv !== rx[i] || ev !== ex[i]) begin
        errors++;
        $display("FAIL pow2[%0d] a=%h got res=%h err=%b want res=%h err=%b", i, av[i], rv, ev, rx[i], ex[i]);
      end
      checks++;
      if (lat != 4 || ro_n !== 1'b0) begin
        errors++;
        $display("FAIL pow2_lat[%0d] got lat=%0d r_o_next=%b want 4 0", i, lat, ro_n);
      end
    end
  endtask

  task automatic test_div();
    logic [31:0] av [9] = '{32'h40C00000, 32'h3F800000, 32'hC0800000, 32'h80000000, 32'h40000000,
                            32'h7F800000, 32'h00800000, 32'h7F000000, 32'h40E00000};
    logic [31:0] bv [9] = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h40000000, 32'h00000000,
                            32'h40000000, 32'h7F000000, 32'h00800000, 32'h40000000};
    logic [31:0] rx [9] = '{32'h40400000, 32'h3EAAAAAA, 32'hC0000000, 32'h80000000, 32'h00000000,
                            32'h00000000, 32'h00000000, 32'h00000000, 32'h40600000};
    logic        ex [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    int lat; logic [31:0] rv; logic ev, bz, ro_n, bz_n;
    for (int i = 0; i < 9; i++) begin
      run_op(2'b10, av[i], bv[i], lat, rv, ev, bz, ro_n, bz_n);
      checks++;
      if (rv !== rx[i] || ev !== ex[i]) begin
        errors++;
        $display("FAIL div[%0d] a=%h b=%h got res=%h err=%b want res=%h err=%b",
                 i, av[i], bv[i], rv, ev, rx[i], ex[i]);
      end
      checks++;
      if (lat != 27) begin
        errors++;
        $display("FAIL div_lat[%0d] got %0d want 27", i, lat);
      end
    end
  endtask

  // A second start pulse during a divide by zero must be dropped.
  task automatic test_ignore_busy();
    int pulses = 0; int first = 0; logic [31:0] rv = '1; logic ev = 1'b0;
    @(negedge clk);
    op = 2'b10; a = 32'h40000000; b = 32'h00000000; r_i = 1'b1;
    @(posedge clk); #1;
    r_i = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (r_o) begin
        pulses++;
        if (first == 0) begin first = k; rv = res; ev = err; end
      end
      if (k == 5) begin op = 2'b00; b = 32'h40200000; r_i = 1'b1; end
      if (k == 6) r_i = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (pulses != 1 || first != 27) begin
      errors++;
      $display("FAIL ignore_busy got pulses=%0d first=%0d want 1 27", pulses, first);
    end
    checks++;
    if (rv !== 32'd0 || ev !== 1'b1) begin
      errors++;
      $display("FAIL ignore_busy_res got res=%h err=%b want 0 1", rv, ev);
    end
  endtask

  // r_i held high across a whole operation starts only once.
  task automatic test_held();
    int pulses = 0; int lat; logic [31:0] rv; logic ev, bz, ro_n, bz_n;
    @(negedge clk);
    op = 2'b00; a = '0; b = 32'h40200000; r_i = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 20; k++) begin
      if (r_o) pulses++;
      if (k == 12) r_i = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL held_start got pulses=%0d want 1", pulses);
    end
    run_op(2'b00, 32'h0, 32'h40400000, lat, rv, ev, bz, ro_n, bz_n);
    checks++;
    if (rv !== 32'd0 || lat != 3) begin
      errors++;
      $display("FAIL held_restart got res=%h lat=%0d want 0 3", rv, lat);
    end
  endtask

  // Reset in the middle of a divide clears outputs at once and drops the result.
  task automatic test_reset_mid();
    int lat; int pulses = 0; logic [31:0] rv; logic ev, bz, ro_n, bz_n;
    run_op(2'b01, 32'h40400000, 32'h0, lat, rv, ev, bz, ro_n, bz_n);
    @(negedge clk);
    op = 2'b10; a = 32'h40C00000; b = 32'h40000000; r_i = 1'b1;
    @(posedge clk); #1;
    r_i = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b1 || res !== 32'h41100000) begin
      errors++;
      $display("FAIL mid_before got busy=%b res=%h want 1 41100000", busy, res);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({r_o, busy, err, res} !== 35'd0) begin
      errors++;
      $display("FAIL mid_reset got r_o=%b busy=%b err=%b res=%h want all 0", r_o, busy, err, res);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (r_o) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL mid_no_done got pulses=%0d want 0", pulses);
    end
    run_op(2'b00, 32'h0, 32'h40200000, lat, rv, ev, bz, ro_n, bz_n);
    checks++;
    if (rv !== 32'd1 || ev !== 1'b0 || lat != 3) begin
      errors++;
      $display("FAIL mid_after got res=%h err=%b lat=%0d want 1 0 3", rv, ev, lat);
    end
  endtask

  initial begin
    test_reset();
    test_checkfr();
    test_pow2();
    test_div();
    test_ignore_busy();
    test_held();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
